spi_master: RTL

- Upstream stage for the SPI slave memory port. Accepts one write request per handshake on the system clock and serialises it as a single SPI frame on sck/mosi/ss_n.
- Frame is {write, size[1:0], addr[AWIDTH-1:0], data[DWIDTH-1:0]}, sent MSB first. It is framed by ss_n and uses the programmable SPI mode (CPOL/CPHA).
- Captures miso during the frame and returns the captured word for future read support.

---
 rtl/spi_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
//============================================================================
// Module   : spi_master
// Purpose  : Serialises one {write,size,addr,data} request per handshake as
//            an SPI frame (CPOL/CPHA selectable) and captures miso.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module spi_master #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_data_i,
    output logic              done_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              ss_n_o
);

    localparam int c_NBITS = AWIDTH + 3 + DWIDTH;
    localparam int c_HW    = $clog2(CLK_DIV) + 1;
    localparam int c_TWRAW = $clog2(2 * c_NBITS + 1);
    localparam int c_TW    = (c_TWRAW > 6) ? c_TWRAW : 6;

    localparam logic [c_HW-1:0] c_HLAST = c_HW'(CLK_DIV - 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(2 * c_NBITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t               state_q;
    logic                 ss_n_q;
    logic                 sck_q;
    logic                 mosi_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 cpha_q;
    logic [DWIDTH-1:0]    rdata_q;
    logic [c_NBITS-1:0]   tx_q;
    logic [DWIDTH-1:0]    rx_q;
    logic [c_HW-1:0]      hcnt_q;
    logic [c_TW-1:0]      tcnt_q;
    logic [c_TW-1:0]      tcnt_d;
    logic [c_NBITS-1:0]   w_frame;

    assign w_frame = {req_write_i, req_size_i, req_addr_i, req_data_i};
    assign tcnt_d  = tcnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            cpha_q  <= 1'b0;
            rdata_q <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            hcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q <= mode_i[1];
                    if (req_valid_i) begin
                        cpha_q  <= mode_i[0];
                        ss_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        hcnt_q  <= '0;
                        tcnt_q  <= '0;
                        state_q <= SETUP;
                        // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on that edge
                        if (mode_i[0]) begin
                            mosi_q <= 1'b0;
                            tx_q   <= w_frame;
                        end else begin
                            mosi_q <= w_frame[c_NBITS-1];
                            tx_q   <= {w_frame[c_NBITS-2:0], 1'b0};
                        end
                    end
                end
                SETUP: begin
                    if (hcnt_q == c_HLAST) begin
                        hcnt_q  <= '0;
                        state_q <= SHIFT;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (hcnt_q == c_HLAST) begin
                        hcnt_q <= '0;
                        sck_q  <= ~sck_q;
                        tcnt_q <= tcnt_d;
                        // odd toggle count marks a leading edge
                        if (tcnt_d[0]) begin
                            if (cpha_q) begin
                                mosi_q <= tx_q[c_NBITS-1];
                                tx_q   <= {tx_q[c_NBITS-2:0], 1'b0};
                            end else begin
                                rx_q <= {rx_q[DWIDTH-2:0], miso_i};
                            end
                        end else begin
                            if (cpha_q) begin
                                rx_q <= {rx_q[DWIDTH-2:0], miso_i};
                            end else if (tcnt_d != c_TLAST) begin
                                mosi_q <= tx_q[c_NBITS-1];
                                tx_q   <= {tx_q[c_NBITS-2:0], 1'b0};
                            end
                        end
                        if (tcnt_d == c_TLAST) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hcnt_q == c_HLAST) begin
                        hcnt_q  <= '0;
                        ss_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= GAP;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (hcnt_q == c_HLAST) begin
                        hcnt_q  <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        rdata_q <= rx_q;
                        state_q <= IDLE;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign sck_o       = sck_q;
    assign mosi_o      = mosi_q;
    assign ss_n_o      = ss_n_q;

endmodule

`default_nettype wire
